// File: rtl/fpnew_opgroup_result_sequencer.sv
// Result sequencer for an operation group: returns slice results in issue order or round-robin completion order.
// Optional output pipeline register enabled by defining FPNEW_SEQ_OUT_REG_EN.
module fpnew_opgroup_result_sequencer #(
  parameter int unsigned NumSlices = 5,
  parameter int unsigned ResWidth  = 32,
  parameter int unsigned TagWidth  = 8,
  parameter int unsigned Depth     = 4,
  parameter bit          InOrder   = 1'b1,
  localparam int unsigned IdxW     = $clog2(NumSlices),
  localparam int unsigned CntW     = $clog2(Depth) + 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               issue_valid_i,
  input  logic [IdxW-1:0]                    issue_slice_i,
  output logic                               issue_ready_o,
  input  logic [NumSlices-1:0]               slice_valid_i,
  output logic [NumSlices-1:0]               slice_ready_o,
  input  logic [NumSlices-1:0][ResWidth-1:0] slice_result_i,
  input  logic [NumSlices-1:0][4:0]          slice_status_i,
  input  logic [NumSlices-1:0]               slice_ext_bit_i,
  input  logic [NumSlices-1:0][TagWidth-1:0] slice_tag_i,
  input  logic                               flush_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [ResWidth-1:0]                out_result_o,
  output logic [4:0]                         out_status_o,
  output logic                               out_ext_bit_o,
  output logic [TagWidth-1:0]                out_tag_o,
  output logic [CntW-1:0]                    outstanding_o,
  output logic                               busy_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [IdxW-1:0] fifo_q [Depth];
  logic [IdxW-1:0] rr_q, rr_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q;

  logic            empty;
  logic            issue_ready_int;
  logic            issue_fire;
  logic            up_ready;
  logic            sel_valid;
  logic [IdxW-1:0] sel_idx;
  logic            pop;
  logic [NumSlices-1:0] slice_ready_c;
  int unsigned     cand;

  assign empty           = (cnt_q == '0);
  assign issue_ready_int = (cnt_q < CntW'(Depth)) & ~flush_i;
  assign issue_ready_o   = rst_ni & issue_ready_int;
  assign issue_fire      = issue_valid_i & issue_ready_o;

`ifdef FPNEW_SEQ_OUT_REG_EN
  logic                reg_valid_q;
  logic [ResWidth-1:0] reg_result_q;
  logic [4:0]          reg_status_q;
  logic                reg_ext_q;
  logic [TagWidth-1:0] reg_tag_q;

  // Register accepts whenever it is empty or being drained this cycle.
  assign up_ready = ~reg_valid_q | out_ready_i;
`else
  assign up_ready = out_ready_i;
`endif

  // Source selection: FIFO head in issue order, or locked/round-robin grant.
  always_comb begin
    sel_idx   = '0;
    sel_valid = 1'b0;
    cand      = 0;
    if (InOrder) begin
      sel_idx   = fifo_q[rd_ptr_q];
      sel_valid = ~empty & slice_valid_i[sel_idx];
    end else if (lock_q) begin
      sel_idx   = lock_idx_q;
      sel_valid = ~empty & slice_valid_i[lock_idx_q];
    end else begin
      for (int unsigned k = 0; k < NumSlices; k++) begin
        cand = 32'(rr_q) + k;
        if (cand >= NumSlices) cand = cand - NumSlices;
        if (!sel_valid && slice_valid_i[cand]) begin
          sel_valid = 1'b1;
          sel_idx   = IdxW'(cand);
        end
      end
      sel_valid = sel_valid & ~empty;
    end
  end

  assign pop = sel_valid & up_ready & ~flush_i;

  always_comb begin
    slice_ready_c = '0;
    if (flush_i) begin
      slice_ready_c = '1;
    end else if (InOrder) begin
      slice_ready_c[sel_idx] = ~empty & up_ready;
    end else begin
      slice_ready_c[sel_idx] = sel_valid & up_ready;
    end
  end

  assign slice_ready_o = rst_ni ? slice_ready_c : '0;

  always_comb begin
    cnt_d  = cnt_q + CntW'(issue_fire) - CntW'(pop);
    rr_d   = rr_q;
    lock_d = 1'b0;
    if (pop) begin
      rr_d = (32'(sel_idx) == NumSlices - 1) ? '0 : sel_idx + IdxW'(1);
    end
    if (!InOrder) lock_d = sel_valid & ~up_ready;
    if (flush_i) begin
      cnt_d  = '0;
      rr_d   = '0;
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) fifo_q[i] <= '0;
    end else begin
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= sel_idx;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (issue_fire) begin
          fifo_q[wr_ptr_q] <= issue_slice_i;
          wr_ptr_q         <= wr_ptr_q + PtrW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

`ifdef FPNEW_SEQ_OUT_REG_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      reg_valid_q  <= 1'b0;
      reg_result_q <= '0;
      reg_status_q <= '0;
      reg_ext_q    <= 1'b0;
      reg_tag_q    <= '0;
    end else if (flush_i) begin
      reg_valid_q <= 1'b0;
    end else if (up_ready) begin
      reg_valid_q <= sel_valid;
      if (sel_valid) begin
        reg_result_q <= slice_result_i[sel_idx];
        reg_status_q <= slice_status_i[sel_idx];
        reg_ext_q    <= slice_ext_bit_i[sel_idx];
        reg_tag_q    <= slice_tag_i[sel_idx];
      end
    end
  end

  assign out_valid_o   = rst_ni & reg_valid_q & ~flush_i;
  assign out_result_o  = rst_ni ? reg_result_q : '0;
  assign out_status_o  = rst_ni ? reg_status_q : '0;
  assign out_ext_bit_o = rst_ni & reg_ext_q;
  assign out_tag_o     = rst_ni ? reg_tag_q : '0;
  assign busy_o        = rst_ni & ((cnt_q != '0) | reg_valid_q);
`else
  assign out_valid_o   = rst_ni & sel_valid & ~flush_i;
  assign out_result_o  = rst_ni ? slice_result_i[sel_idx] : '0;
  assign out_status_o  = rst_ni ? slice_status_i[sel_idx] : '0;
  assign out_ext_bit_o = rst_ni & slice_ext_bit_i[sel_idx];
  assign out_tag_o     = rst_ni ? slice_tag_i[sel_idx] : '0;
  assign busy_o        = rst_ni & (cnt_q != '0);
`endif

  assign outstanding_o = rst_ni ? cnt_q : '0;

  // A slice presenting a result while nothing is tracked breaks the protocol.
  always @(posedge clk_i) begin
    if (rst_ni && !flush_i)
      assert (!(empty && (|slice_valid_i)))
        else $error("slice result valid with no outstanding op");
  end

endmodule
